// File: rtl/rob_multiport_if.sv
// rob_multiport_if: issue, query, writeback, store-handshake and commit signals of rob_multiport
interface rob_multiport_if #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int WB_PORTS = 2
);
  logic                      rdy_in;
  logic                      iss_valid;
  logic                      iss_ready;
  logic [1:0]                iss_type;
  logic [31:0]               iss_value;
  logic [4:0]                iss_rd;
  logic [IDX_W-1:0]          tail_idx;
  logic                      full;
  logic [IDX_W:0]            count;
  logic [IDX_W-1:0]          q_idx1;
  logic [IDX_W-1:0]          q_idx2;
  logic                      q_ready1;
  logic                      q_ready2;
  logic [31:0]               q_value1;
  logic [31:0]               q_value2;
  logic [WB_PORTS-1:0]       wb_valid;
  logic [WB_PORTS*IDX_W-1:0] wb_idx;
  logic [WB_PORTS*32-1:0]    wb_value;
  logic [WB_PORTS-1:0]       wb_mispred;
  logic [IDX_W-1:0]          head_idx;
  logic                      head_valid;
  logic                      st_ok;
  logic                      commit_valid;
  logic [4:0]                commit_rd;
  logic [31:0]               commit_value;
  logic [IDX_W-1:0]          commit_idx;
  logic                      clear;
  logic [31:0]               next_pc;
  logic                      err_overflow;
  modport master (
    output rdy_in, iss_valid, iss_ready, iss_type, iss_value, iss_rd, q_idx1, q_idx2,
           wb_valid, wb_idx, wb_value, wb_mispred, st_ok,
    input  tail_idx, full, count, q_ready1, q_ready2, q_value1, q_value2, head_idx, head_valid,
           commit_valid, commit_rd, commit_value, commit_idx, clear, next_pc, err_overflow
  );
  modport slave (
    input  rdy_in, iss_valid, iss_ready, iss_type, iss_value, iss_rd, q_idx1, q_idx2,
           wb_valid, wb_idx, wb_value, wb_mispred, st_ok,
    output tail_idx, full, count, q_ready1, q_ready2, q_value1, q_value2, head_idx, head_valid,
           commit_valid, commit_rd, commit_value, commit_idx, clear, next_pc, err_overflow
  );
endinterface

// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with multi-channel writeback, in-order commit and mispredict flush.
// Define ROB_WB_BYPASS_EN to let operand queries see same-cycle writebacks.
module rob_multiport #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int WB_PORTS = 2
) (
  input logic clk_in,
  input logic rst_n_in,
  rob_multiport_if.slave bus
);
  localparam logic [1:0] T_ST = 2'd1;
  localparam logic [1:0] T_BR = 2'd2;
  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, mispred_q, mispred_d;
  logic [1:0] type_q [DEPTH];
  logic [1:0] type_d [DEPTH];
  logic [31:0] value_q [DEPTH];
  logic [31:0] value_d [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [4:0] rd_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, wi;
  logic [IDX_W:0] count_q, count_d;
  logic clear_q, clear_d, err_q, err_d;
  logic [31:0] npc_q, npc_d;
  logic full, flush, live, head_ok, head_rg, do_commit, do_issue;
  assign full = count_q == (IDX_W+1)'(DEPTH);
  assign flush = clear_q && bus.rdy_in;
  assign live = bus.rdy_in && !flush;
  assign head_rg = type_q[head_q] != T_ST && type_q[head_q] != T_BR;
  assign head_ok = busy_q[head_q] && ready_q[head_q] && (type_q[head_q] != T_ST || bus.st_ok);
  assign do_commit = head_ok && live;
  assign do_issue = bus.iss_valid && !full && live;
  always_comb begin
    busy_d = busy_q;
    ready_d = ready_q;
    mispred_d = mispred_q;
    type_d = type_q;
    value_d = value_q;
    rd_d = rd_q;
    head_d = head_q;
    tail_d = tail_q;
    clear_d = clear_q;
    npc_d = npc_q;
    wi = '0;
    count_d = count_q + (IDX_W+1)'(do_issue) - (IDX_W+1)'(do_commit);
    err_d = err_q || (bus.iss_valid && full && live);
    if (live) begin
      // ascending order lets the highest channel win on a shared index
      for (int k = 0; k < WB_PORTS; k++) begin
        wi = bus.wb_idx[k*IDX_W +: IDX_W];
        if (bus.wb_valid[k] && busy_q[wi]) begin
          ready_d[wi] = 1'b1;
          value_d[wi] = bus.wb_value[k*32 +: 32];
          if (type_q[wi] == T_BR) mispred_d[wi] = bus.wb_mispred[k];
        end
      end
    end
    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d = head_q + IDX_W'(1);
      if (type_q[head_q] == T_BR && mispred_q[head_q]) begin
        clear_d = 1'b1;
        npc_d = value_q[head_q];
      end
    end
    if (do_issue) begin
      busy_d[tail_q] = 1'b1;
      ready_d[tail_q] = bus.iss_ready;
      mispred_d[tail_q] = 1'b0;
      type_d[tail_q] = bus.iss_type;
      value_d[tail_q] = bus.iss_value;
      rd_d[tail_q] = bus.iss_rd;
      tail_d = tail_q + IDX_W'(1);
    end
    if (flush) begin
      busy_d = '0;
      ready_d = '0;
      mispred_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      clear_d = 1'b0;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
      ready_q <= '0;
      mispred_q <= '0;
      type_q <= '{default: '0};
      value_q <= '{default: '0};
      rd_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      clear_q <= 1'b0;
      npc_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ready_q <= ready_d;
      mispred_q <= mispred_d;
      type_q <= type_d;
      value_q <= value_d;
      rd_q <= rd_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      clear_q <= clear_d;
      npc_q <= npc_d;
      err_q <= err_d;
    end
  end
  function automatic logic [32:0] query(input logic [IDX_W-1:0] i);
    logic [32:0] r;
    r = {ready_q[i], value_q[i]};
`ifdef ROB_WB_BYPASS_EN
    for (int k = 0; k < WB_PORTS; k++)
      if (!ready_q[i] && bus.wb_valid[k] && bus.wb_idx[k*IDX_W +: IDX_W] == i)
        r = {1'b1, bus.wb_value[k*32 +: 32]};
`endif
    return r;
  endfunction
  assign {bus.q_ready1, bus.q_value1} = query(bus.q_idx1);
  assign {bus.q_ready2, bus.q_value2} = query(bus.q_idx2);
  assign bus.tail_idx = tail_q;
  assign bus.full = full;
  assign bus.count = count_q;
  assign bus.head_idx = head_q;
  assign bus.head_valid = busy_q[head_q];
  assign bus.commit_valid = head_ok && head_rg && bus.rdy_in;
  assign bus.commit_rd = bus.commit_valid ? rd_q[head_q] : '0;
  assign bus.commit_value = bus.commit_valid ? value_q[head_q] : '0;
  assign bus.commit_idx = bus.commit_valid ? head_q : '0;
  assign bus.clear = clear_q;
  assign bus.next_pc = npc_q;
  assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed plus randomized checks of rob_multiport against a queue-based reference model
module tb_rob_multiport;
  localparam int DEPTH = 16, IDX_W = 4, WB_PORTS = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  rob_multiport_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS)) bus ();
  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus.slave)
  );
  typedef struct {int idx; int typ; int rd; bit rdy; bit mp;} ent_t;
  ent_t rob[$];
  int m_head;
  bit m_clear, m_err;
  logic [31:0] m_npc;
  logic [31:0] m_val [DEPTH];
  int n_tests = 0, n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int m_tail();
    return (m_head + rob.size()) % DEPTH;
  endfunction
  function automatic bit is_rg(int t);
    return t != 1 && t != 2;
  endfunction
  function automatic bit m_cond();
    return rob.size() > 0 && rob[0].rdy && (rob[0].typ != 1 || bus.st_ok);
  endfunction
  function automatic int find(int i);
    for (int p = 0; p < rob.size(); p++) if (rob[p].idx == i) return p;
    return -1;
  endfunction
  task automatic m_reset();
    rob.delete();
    m_head = 0; m_clear = 0; m_err = 0; m_npc = 0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
  endtask
  task automatic m_query(input int i, output bit r, output logic [31:0] v);
    int p;
    p = find(i);
    r = p >= 0 && rob[p].rdy;
    v = m_val[i];
`ifdef ROB_WB_BYPASS_EN
    if (!r)
      for (int k = 0; k < WB_PORTS; k++)
        if (bus.wb_valid[k] && int'(bus.wb_idx[k*IDX_W +: IDX_W]) == i) begin
          r = 1; v = bus.wb_value[k*32 +: 32];
        end
`endif
  endtask
  task automatic compare();
    bit cv, r;
    logic [31:0] v;
    int hi;
    cv = m_cond() && is_rg(rob[0].typ) && bus.rdy_in;
    hi = rob.size() > 0 ? rob[0].idx : 0;
    chk("count", 32'(bus.count), rob.size());
    chk("full", 32'(bus.full), 32'(rob.size() == DEPTH));
    chk("tail_idx", 32'(bus.tail_idx), m_tail());
    chk("head_idx", 32'(bus.head_idx), m_head);
    chk("head_valid", 32'(bus.head_valid), 32'(rob.size() > 0));
    chk("commit_valid", 32'(bus.commit_valid), 32'(cv));
    chk("commit_rd", 32'(bus.commit_rd), cv ? rob[0].rd : 0);
    chk("commit_value", bus.commit_value, cv ? m_val[hi] : 0);
    chk("commit_idx", 32'(bus.commit_idx), cv ? hi : 0);
    chk("clear", 32'(bus.clear), 32'(m_clear));
    chk("next_pc", bus.next_pc, m_npc);
    chk("err_overflow", 32'(bus.err_overflow), 32'(m_err));
    m_query(int'(bus.q_idx1), r, v);
    chk("q_ready1", 32'(bus.q_ready1), 32'(r));
    chk("q_value1", bus.q_value1, v);
    m_query(int'(bus.q_idx2), r, v);
    chk("q_ready2", 32'(bus.q_ready2), 32'(r));
    chk("q_value2", bus.q_value2, v);
  endtask
  task automatic m_update();
    bit c;
    int pre, t, p, wi;
    ent_t h;
    logic [31:0] hv;
    if (!bus.rdy_in) return;
    if (m_clear) begin
      rob.delete(); m_head = 0; m_clear = 0;
      return;
    end
    c = m_cond();
    pre = rob.size();
    t = m_tail();
    if (pre > 0) begin h = rob[0]; hv = m_val[h.idx]; end
    for (int k = 0; k < WB_PORTS; k++) begin
      wi = int'(bus.wb_idx[k*IDX_W +: IDX_W]);
      p = find(wi);
      if (bus.wb_valid[k] && p >= 0) begin
        rob[p].rdy = 1;
        m_val[wi] = bus.wb_value[k*32 +: 32];
        if (rob[p].typ == 2) rob[p].mp = bus.wb_mispred[k];
      end
    end
    if (c) begin
      if (h.typ == 2 && h.mp) begin m_clear = 1; m_npc = hv; end
      void'(rob.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (bus.iss_valid) begin
      if (pre == DEPTH) m_err = 1;
      else begin
        rob.push_back('{t, int'(bus.iss_type), int'(bus.iss_rd), bus.iss_ready, 1'b0});
        m_val[t] = bus.iss_value;
      end
    end
  endtask
  task automatic cyc();
    #1 compare();
    @(posedge clk);
    #1 m_update();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.rdy_in = 1; bus.iss_valid = 0; bus.iss_ready = 0; bus.iss_type = 0;
    bus.iss_value = 0; bus.iss_rd = 0; bus.q_idx1 = 0; bus.q_idx2 = 0;
    bus.wb_valid = 0; bus.wb_idx = 0; bus.wb_value = 0; bus.wb_mispred = 0; bus.st_ok = 0;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1;
  endtask
  task automatic issue(input int typ, input bit rdy, input int rd, input logic [31:0] val);
    bus.iss_valid = 1; bus.iss_type = 2'(typ); bus.iss_ready = rdy;
    bus.iss_rd = 5'(rd); bus.iss_value = val;
    cyc();
    bus.iss_valid = 0;
  endtask
  task automatic wb0(input int idx, input logic [31:0] val, input bit mp);
    bus.wb_valid = 2'b01; bus.wb_idx = 8'(idx); bus.wb_value = {32'h0, val};
    bus.wb_mispred = {1'b0, mp};
  endtask
  initial begin
    m_reset();
    do_reset();
    #1 chk("rst_count", 32'(bus.count), 0);
    chk("rst_head_valid", 32'(bus.head_valid), 0);
    for (int i = 0; i < DEPTH; i++) issue(0, 0, i, 32'(i * 3));
    #1 chk("full_flag", 32'(bus.full), 1);
    chk("full_count", 32'(bus.count), 16);
    chk("full_tail", 32'(bus.tail_idx), 0);
    issue(0, 0, 1, 32'h55);
    #1 chk("ovf_err", 32'(bus.err_overflow), 1);
    chk("ovf_tail", 32'(bus.tail_idx), 0);
    chk("ovf_count", 32'(bus.count), 16);
    do_reset();
    issue(0, 0, 5, 0);
    wb0(0, 32'h1234, 0);
    cyc();
    idle();
    #1 chk("rg_commit_valid", 32'(bus.commit_valid), 1);
    chk("rg_commit_rd", 32'(bus.commit_rd), 5);
    chk("rg_commit_value", bus.commit_value, 32'h1234);
    chk("rg_commit_idx", 32'(bus.commit_idx), 0);
    cyc();
    #1 chk("rg_head_after", 32'(bus.head_idx), 1);
    do_reset();
    issue(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus.st_ok = 0;
      #1 chk("st_wait_head", 32'(bus.head_idx), 0);
      chk("st_wait_cv", 32'(bus.commit_valid), 0);
      cyc();
    end
    bus.st_ok = 1;
    #1 chk("st_ok_cv", 32'(bus.commit_valid), 0);
    cyc();
    bus.st_ok = 0;
    #1 chk("st_head_after", 32'(bus.head_idx), 1);
    do_reset();
    issue(0, 1, 1, 32'd11);
    issue(0, 1, 2, 32'd22);
    issue(2, 0, 0, 0);
    wb0(2, 32'h80, 1);
    cyc();
    idle();
    cyc();
    #1 chk("br_clear", 32'(bus.clear), 1);
    chk("br_next_pc", bus.next_pc, 32'h80);
    cyc();
    #1 chk("fl_count", 32'(bus.count), 0);
    chk("fl_head", 32'(bus.head_idx), 0);
    chk("fl_tail", 32'(bus.tail_idx), 0);
    chk("fl_clear", 32'(bus.clear), 0);
    do_reset();
    for (int i = 0; i < 4; i++) issue(0, 0, i, 32'(100 + i));
    bus.wb_valid = 2'b11; bus.wb_idx = {4'd3, 4'd3}; bus.wb_value = {32'hB, 32'hA};
    bus.q_idx1 = 3;
`ifdef ROB_WB_BYPASS_EN
    #1 chk("byp_q_ready", 32'(bus.q_ready1), 1);
    chk("byp_q_value", bus.q_value1, 32'hB);
`else
    #1 chk("byp_q_ready", 32'(bus.q_ready1), 0);
    chk("byp_q_value", bus.q_value1, 32'd103);
`endif
    cyc();
    idle();
    bus.q_idx1 = 3;
    #1 chk("dual_q_ready", 32'(bus.q_ready1), 1);
    chk("dual_q_value", bus.q_value1, 32'hB);
    cyc();
    do_reset();
    issue(2, 0, 0, 0);
    for (int i = 0; i < 7; i++) issue(0, 0, i + 1, 32'(i));
    wb0(0, 32'h40, 1);
    cyc();
    idle();
    cyc();
    #1 chk("pre_rst_clear", 32'(bus.clear), 1);
    chk("pre_rst_count", 32'(bus.count), 7);
    rst_n = 0;
    #1 chk("arst_count", 32'(bus.count), 0);
    chk("arst_full", 32'(bus.full), 0);
    chk("arst_tail", 32'(bus.tail_idx), 0);
    chk("arst_head", 32'(bus.head_idx), 0);
    chk("arst_head_valid", 32'(bus.head_valid), 0);
    chk("arst_commit_valid", 32'(bus.commit_valid), 0);
    chk("arst_commit_rd", 32'(bus.commit_rd), 0);
    chk("arst_commit_value", bus.commit_value, 0);
    chk("arst_commit_idx", 32'(bus.commit_idx), 0);
    chk("arst_clear", 32'(bus.clear), 0);
    chk("arst_next_pc", bus.next_pc, 0);
    chk("arst_err", 32'(bus.err_overflow), 0);
    @(negedge clk);
    m_reset();
    rst_n = 1;
    for (int n = 0; n < 4000; n++) begin
      bus.rdy_in = ($urandom % 8) != 0;
      bus.iss_valid = ($urandom % 2) && (rob.size() < DEPTH || ($urandom % 8) == 0);
      bus.iss_type = 2'($urandom % 4);
      bus.iss_ready = ($urandom % 3) == 0;
      bus.iss_value = $urandom;
      bus.iss_rd = 5'($urandom);
      bus.st_ok = $urandom % 2;
      bus.q_idx1 = IDX_W'($urandom);
      bus.q_idx2 = (rob.size() > 0) ? IDX_W'(rob[$urandom_range(0, rob.size() - 1)].idx) : IDX_W'($urandom);
      for (int k = 0; k < WB_PORTS; k++) begin
        bus.wb_valid[k] = ($urandom % 5) < 2;
        bus.wb_idx[k*IDX_W +: IDX_W] = (rob.size() > 0 && ($urandom % 4) != 0) ?
          IDX_W'(rob[$urandom_range(0, rob.size() - 1)].idx) : IDX_W'($urandom);
        bus.wb_value[k*32 +: 32] = $urandom;
        bus.wb_mispred[k] = ($urandom % 4) == 0;
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
